// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, 16x16 register file, instruction decode and load-use hazard stall.
// Optional macro ID_BYPASS_EN makes a same-cycle writeback visible to register reads (write-through).
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr_in,
    input  logic [15:0] PC_inc_in,
    input  logic        instr_valid_in,
    input  logic        flush,
    input  logic        wb_wen,
    input  logic [3:0]  wb_wd,
    input  logic [15:0] wb_data,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_wd,
    output logic        stall,
    output logic [15:0] PC_inc_out,
    output logic [15:0] rdata_1_out,
    output logic [15:0] rdata_2_out,
    output logic [15:0] ext_data_out,
    output logic [7:0]  hbu_imm_out,
    output logic [3:0]  rd_1_out,
    output logic [3:0]  rd_2_out,
    output logic [3:0]  wd_out,
    output logic [3:0]  opcode_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        halt_out
);

    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_LLB = 4'hA;
    localparam logic [3:0] OP_LHB = 4'hB;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_PCS = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // rst_n is active-high despite its name
    logic        r_valid;
    logic [15:0] r_instr;
    logic [15:0] r_pc_inc;
    logic [15:0] r_rf [16];

    logic [3:0]  w_opcode;
    logic        w_is_alu, w_is_imm_alu, w_is_lw, w_is_sw, w_is_llb, w_is_lhb;
    logic        w_is_b, w_is_br, w_is_pcs, w_is_hlt;
    logic [3:0]  w_rs1, w_rs2;
    logic        w_uses_rs1, w_uses_rs2, w_writes, w_issue;
    logic        w_byp_1, w_byp_2;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_valid  <= 1'b0;
            r_instr  <= 16'h0000;
            r_pc_inc <= 16'h0000;
        end else if (flush) begin
            r_valid  <= 1'b0;
        end else if (!stall) begin
            r_valid  <= instr_valid_in;
            r_instr  <= instr_in;
            r_pc_inc <= PC_inc_in;
        end
    end

    // R0 is never written, so it reads zero without special-casing the array
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_rf[i] <= 16'h0000;
            end
        end else if (wb_wen && (wb_wd != 4'h0)) begin
            r_rf[wb_wd] <= wb_data;
        end
    end

    assign w_opcode     = r_instr[15:12];
    assign w_is_alu     = ~w_opcode[3];
    assign w_is_imm_alu = (w_opcode == 4'h4) || (w_opcode == 4'h5) || (w_opcode == 4'h6);
    assign w_is_lw      = (w_opcode == OP_LW);
    assign w_is_sw      = (w_opcode == OP_SW);
    assign w_is_llb     = (w_opcode == OP_LLB);
    assign w_is_lhb     = (w_opcode == OP_LHB);
    assign w_is_b       = (w_opcode == OP_B);
    assign w_is_br      = (w_opcode == OP_BR);
    assign w_is_pcs     = (w_opcode == OP_PCS);
    assign w_is_hlt     = (w_opcode == OP_HLT);

    assign w_rs1 = (w_is_llb || w_is_lhb) ? r_instr[11:8] : r_instr[7:4];
    assign w_rs2 = w_is_sw ? r_instr[11:8] : r_instr[3:0];

    // LLB/LHB merge into their destination, so they read it; shift-immediates and B/PCS/HLT skip rs2
    assign w_uses_rs1 = w_is_alu || w_is_lw || w_is_sw || w_is_llb || w_is_lhb || w_is_br;
    assign w_uses_rs2 = (w_is_alu && !w_is_imm_alu) || w_is_sw;
    assign w_writes   = w_is_alu || w_is_lw || w_is_llb || w_is_lhb || w_is_pcs;

    assign stall = r_valid && ex_mem_read && (ex_wd != 4'h0) &&
                   ((w_uses_rs1 && (ex_wd == w_rs1)) || (w_uses_rs2 && (ex_wd == w_rs2)));
    assign w_issue = r_valid && !stall;

`ifdef ID_BYPASS_EN
    assign w_byp_1 = wb_wen && (wb_wd != 4'h0) && (wb_wd == w_rs1);
    assign w_byp_2 = wb_wen && (wb_wd != 4'h0) && (wb_wd == w_rs2);
`else
    assign w_byp_1 = 1'b0;
    assign w_byp_2 = 1'b0;
`endif

    assign rdata_1_out = w_byp_1 ? wb_data : r_rf[w_rs1];
    assign rdata_2_out = w_byp_2 ? wb_data : r_rf[w_rs2];

    always_comb begin
        ext_data_out = 16'h0000;
        if (w_is_lw || w_is_sw) begin
            ext_data_out = {{11{r_instr[3]}}, r_instr[3:0], 1'b0};
        end else if (w_is_imm_alu) begin
            ext_data_out = {12'h000, r_instr[3:0]};
        end else if (w_is_b) begin
            ext_data_out = {{6{r_instr[8]}}, r_instr[8:0], 1'b0};
        end
    end

    assign PC_inc_out    = r_pc_inc;
    assign hbu_imm_out   = r_instr[7:0];
    assign rd_1_out      = w_rs1;
    assign rd_2_out      = w_rs2;
    assign opcode_out    = w_opcode;
    assign reg_write_out = w_issue && w_writes;
    assign wd_out        = (w_issue && w_writes) ? r_instr[11:8] : 4'h0;
    assign mem_read_out  = w_issue && w_is_lw;
    assign mem_write_out = w_issue && w_is_sw;
    assign halt_out      = w_issue && w_is_hlt;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-high (1 = reset) despite the name.
REQ-003 SHALL have port instr_in, input, 16, fetched instruction.
REQ-004 SHALL have port PC_inc_in, input, 16, PC+2 of fetched instruction.
REQ-005 SHALL have port instr_valid_in, input, 1, fetch output valid.
REQ-006 SHALL have port flush, input, 1, kill instruction entering IF/ID latch (taken branch).
REQ-007 SHALL have ports wb_wen (1), wb_wd (4), wb_data (16), inputs, writeback request.
REQ-008 SHALL have ports ex_mem_read (1), ex_wd (4), inputs, load flag and destination of the instruction currently in ID/EX.
REQ-009 SHALL have port stall, output, 1, hold fetch PC and IF/ID latch.
REQ-010 SHALL have outputs PC_inc_out, rdata_1_out, rdata_2_out, ext_data_out (16 each), hbu_imm_out (8), rd_1_out, rd_2_out, wd_out, opcode_out (4 each), feeding ID/EX.
REQ-011 SHALL have outputs reg_write_out, mem_read_out, mem_write_out, halt_out (1 each).

Function
REQ-012 SHALL contain IF/ID latch {valid, instr[15:0], PC_inc[15:0]}; each edge: flush -> valid=0; else stall -> hold; else load {instr_valid_in, instr_in, PC_inc_in}.
REQ-013 SHALL give flush priority over stall when both are 1 in the same cycle.
REQ-014 SHALL decode combinationally from latch contents; instr_in to ID/EX-side outputs = 1 cycle latency.
REQ-015 SHALL contain 16x16 register file; R0 reads 0 always; write on edge when wb_wen=1 and wb_wd!=0.
REQ-016 SHALL decode opcode=instr[15:12]: 0-7 ALU, 8 LW, 9 SW, A LLB, B LHB, C B, D BR, E PCS, F HLT.
REQ-017 SHALL set rd_1_out=instr[7:4], except LLB/LHB -> instr[11:8]; rd_2_out=instr[3:0], except SW -> instr[11:8].
REQ-018 SHALL set wd_out=instr[11:8] and reg_write_out=1 for ALU, LW, LLB, LHB, PCS; otherwise wd_out=0, reg_write_out=0.
REQ-019 SHALL set ext_data_out: LW/SW sign-ext(instr[3:0])<<1; opcodes 4-6 zero-ext(instr[3:0]); B sign-ext(instr[8:0])<<1; else 0.
REQ-020 SHALL set hbu_imm_out=instr[7:0]; mem_read_out=1 only LW; mem_write_out=1 only SW; halt_out=1 only HLT.
REQ-021 SHALL assert stall when latch valid, ex_mem_read=1, ex_wd!=0, and ex_wd equals a source register actually read by the opcode.
REQ-022 SHALL, when latch invalid or stall=1, drive bubble: reg_write_out, mem_read_out, mem_write_out, halt_out, wd_out all 0.
REQ-023 SHALL pass PC_inc_out = latched PC_inc unchanged, including during bubble.
REQ-024 SHALL hold a load-use stall exactly one cycle (ID/EX then holds bubble, ex_mem_read drops).

Reset
REQ-025 SHALL on rst_n=1 clear latch (valid=0, instr=0, PC_inc=0) and all 16 registers to 0, asynchronously.
REQ-026 SHALL present all outputs 0 while reset asserted and until first valid load; reset mid-stall drops stall immediately.

Configuration
REQ-027 SHALL honour macro ID_BYPASS_EN: defined -> read of register being written same cycle returns wb_data (write-through); undefined -> returns old value, new value visible next cycle.

Verification
REQ-028 Reset: rst_n=1 with R5 previously 0x1234 -> R5 reads 0, all outputs 0, stall=0.
REQ-029 ALU decode: instr 0x1356 valid, R5=0x0010, R6=0x0003 -> next cycle rd_1=5, rd_2=6, rdata_1=0x0010, rdata_2=0x0003, wd=3, reg_write=1.
REQ-030 Load-use: ID/EX holds LW to R4 (ex_mem_read=1, ex_wd=4), latch holds 0x0245 -> stall=1 one cycle, bubble out, same instruction reissued next cycle.
REQ-031 Flush+stall same cycle: flush=1, stall=1 -> latch valid=0, bubble next cycle.
REQ-032 Bypass: wb_wen=1, wb_wd=7, wb_data=0xBEEF while reading R7 -> ID_BYPASS_EN: 0xBEEF; else old value.
REQ-033 Immediates/R0: LW 0x812F -> ext_data=0xFFFE; write R0=0x5555 -> R0 still reads 0.
